// File: rtl/l2_pmem_responder.sv
// Line-addressed pmem responder below the L2: accepts one read/write line request at a time and
// answers after LATENCY cycles with a one-cycle pmem_resp. Optional protocol checker: PMEM_REQ_CHECK_EN.
module l2_pmem_responder #(
  parameter int LINE_BITS   = 256,
  parameter int ADDR_BITS   = 16,
  parameter int OFFSET_BITS = 5,
  parameter int LATENCY     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_resp,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_error
);

  localparam int INDEX_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int LINES      = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   idx_q, rd_idx;
  logic                    is_write_q;
  logic [LINE_BITS-1:0]    wdata_q;
  logic                    req, accept, load_rdata, commit;
  logic [LINE_BITS-1:0]    mem [LINES];

  assign req    = pmem_read | pmem_write;
  assign accept = (state_q == IDLE) && req;

  // Byte-offset bits never select anything; fold them away explicitly.
  logic addr_offset_unused;
  assign addr_offset_unused = ^pmem_address[OFFSET_BITS-1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx     = idx_q;
    load_rdata = 1'b0;
    commit     = 1'b0;
    pmem_resp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Nothing latched yet, so the read index comes straight from the bus.
            state_d    = RESP;
            load_rdata = !pmem_write;
            rd_idx     = pmem_address[ADDR_BITS-1:OFFSET_BITS];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d    = RESP;
          load_rdata = !is_write_q;
        end
      end
      RESP: begin
        pmem_resp = 1'b1;
        commit    = is_write_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pmem_rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_rdata) pmem_rdata <= mem[rd_idx];
    end
  end

  // Request capture; a simultaneous read+write is taken as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= pmem_address[ADDR_BITS-1:OFFSET_BITS];
      is_write_q <= pmem_write;
      wdata_q    <= pmem_wdata;
    end
  end

  // NOTE: the storage array is deliberately not reset; an aborted write never reaches
  // it because reset forces the FSM out of RESP, which kills commit.
  always_ff @(posedge clk) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

`ifdef PMEM_REQ_CHECK_EN
  logic [ADDR_BITS-1:0] addr_q;
  logic                 violation;
  logic                 error_q;

  always_ff @(posedge clk) begin
    if (accept) addr_q <= pmem_address;
  end

  assign violation = (pmem_read & pmem_write) ||
                     ((state_q == BUSY) &&
                      (!req || (pmem_address != addr_q) || (pmem_write != is_write_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            error_q <= 1'b0;
    else if (violation) error_q <= 1'b1;
  end

  assign pmem_error = error_q;
`else
  assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Self-checking bench for l2_pmem_responder: a LATENCY=8 and a LATENCY=1 instance, directed
// scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_l2_pmem_responder;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rd, wr, resp, err;
  logic [1:0][15:0]  addr;
  logic [1:0][255:0] wdata, rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_pmem_responder #(.LATENCY(8)) u_dut8 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr[0]),
    .pmem_wdata(wdata[0]), .pmem_resp(resp[0]), .pmem_rdata(rdata[0]), .pmem_error(err[0]));

  l2_pmem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr[1]),
    .pmem_wdata(wdata[1]), .pmem_resp(resp[1]), .pmem_rdata(rdata[1]), .pmem_error(err[1]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: an accepted request answers exactly LATENCY cycles later,
  // reads return the line as of that moment, writes land at the end of the response cycle.
  bit             pending [2];
  int             acc_cyc [2];
  int             exp_cyc [2];
  bit             acc_wr  [2];
  logic [15:0]    acc_addr[2];
  logic [255:0]   acc_wd  [2];
  logic [255:0]   exp_rd  [2];
  bit             rd_known[2];
  bit             err_m   [2];
  logic [255:0]   mem_m   [int];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          pending[i]  = 1'b0;
          exp_rd[i]   = '0;
          rd_known[i] = 1'b1;
          err_m[i]    = 1'b0;
          check("rst_resp",  256'(resp[i]), '0);
          check("rst_rdata", rdata[i], '0);
          check("rst_error", 256'(err[i]), '0);
        end else begin
          automatic bit idle    = !pending[i];
          automatic bit is_resp = pending[i] && (cyc == exp_cyc[i]);
          automatic int key     = i * 4096 + int'(acc_addr[i][15:5]);
          automatic bit busy    = pending[i] && (cyc > acc_cyc[i]) && (cyc < exp_cyc[i]);
          check("resp", 256'(resp[i]), 256'(is_resp));
          if (is_resp && !acc_wr[i]) begin
            rd_known[i] = mem_m.exists(key);
            if (rd_known[i]) exp_rd[i] = mem_m[key];
          end
          if (rd_known[i]) check("rdata", rdata[i], exp_rd[i]);
`ifdef PMEM_REQ_CHECK_EN
          check("error", 256'(err[i]), 256'(err_m[i]));
          if ((rd[i] & wr[i]) ||
              (busy && (!(rd[i] | wr[i]) || addr[i] != acc_addr[i] || wr[i] != acc_wr[i])))
            err_m[i] = 1'b1;
`else
          check("error", 256'(err[i]), '0);
          if (busy) err_m[i] = 1'b0;
`endif
          if (is_resp) begin
            if (acc_wr[i]) mem_m[key] = acc_wd[i];
            pending[i] = 1'b0;
          end
          if (idle && (rd[i] | wr[i])) begin
            pending[i]  = 1'b1;
            acc_cyc[i]  = cyc;
            exp_cyc[i]  = cyc + lat_of(i);
            acc_wr[i]   = wr[i];
            acc_addr[i] = addr[i];
            acc_wd[i]   = wdata[i];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, hold it until pmem_resp (optionally dropping it or scrambling the
  // bus on a given cycle), then release it in the response cycle. lat = cycles to resp.
  task automatic txn(input int i, input bit r, input bit w, input logic [15:0] a,
                     input logic [255:0] d, input int drop_at, input int chg_at,
                     output int lat);
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    lat = -1;
    for (int k = 1; k <= lat_of(i) + 20; k++) begin
      tick();
      if (k == drop_at) begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
      end
      if (k == chg_at) begin
        addr[i]  = 16'($urandom);
        wdata[i] = {8{$urandom}};
        wr[i]    = ~wr[i];
        rd[i]    = ~wr[i];
      end
      if (resp[i]) begin
        lat = k;
        break;
      end
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
  endtask

  initial begin
    automatic int lat;
    automatic logic [255:0] old_line = {4{64'h0123_4567_89AB_CDEF}};
    rst = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0;
    tick();
    tick();
    check("rst_rdata_lit", rdata[0], '0);
    rst = 1'b0;
    tick();

    // Single read of line 0x010 after preloading it.
    txn(0, 0, 1, 16'h0200, {32{8'hA5}}, 0, 0, lat);
    check("lat_wr_0200", 256'(lat), 256'(8));
    tick();
    txn(0, 1, 0, 16'h0200, '0, 0, 0, lat);
    check("lat_rd_0200", 256'(lat), 256'(8));
    check("rd_0200", rdata[0], {32{8'hA5}});

    // Write then read the same line straight after the write's response.
    tick();
    txn(0, 0, 1, 16'h7FE0, {16{16'h1234}}, 0, 0, lat);
    check("lat_wr_7fe0", 256'(lat), 256'(8));
    txn(0, 1, 0, 16'h7FEF, '0, 0, 0, lat);
    check("lat_raw_7fef", 256'(lat), 256'(9));
    check("rd_7fef", rdata[0], {16{16'h1234}});

    // LATENCY=1: preload lines 0..3, then four held reads back to back.
    for (int n = 0; n < 4; n++) begin
      tick();
      txn(1, 0, 1, 16'(n * 32), {8{32'hC0DE_0000 + 32'(n)}}, 0, 0, lat);
      check("lat1_wr", 256'(lat), 256'(1));
    end
    tick();
    for (int n = 0; n < 4; n++) begin
      txn(1, 1, 0, 16'(n * 32), '0, 0, 0, lat);
      check("lat1_b2b", 256'(lat), 256'((n == 0) ? 1 : 2));
      check("lat1_rd", rdata[1], {8{32'hC0DE_0000 + 32'(n)}});
    end

    // Reset in BUSY cycle 3 of a write aborts it; the line keeps its old contents.
    tick();
    txn(0, 0, 1, 16'h0400, old_line, 0, 0, lat);
    check("lat_wr_0400", 256'(lat), 256'(8));
    tick();
    wr[0] = 1'b1; addr[0] = 16'h0400; wdata[0] = '1;
    tick();
    tick();
    tick();
    rst = 1'b1; wr[0] = 1'b0;
    #1;
    check("abort_resp", 256'(resp[0]), '0);
    check("abort_rdata", rdata[0], '0);
    tick();
    rst = 1'b0;
    tick();
    txn(0, 1, 0, 16'h0400, '0, 0, 0, lat);
    check("lat_rd_0400", 256'(lat), 256'(8));
    check("rd_0400_old", rdata[0], old_line);

    // Read and write together: taken as a write.
    tick();
    txn(0, 1, 1, 16'h0020, '1, 0, 0, lat);
    check("lat_both", 256'(lat), 256'(8));
`ifdef PMEM_REQ_CHECK_EN
    check("err_both", 256'(err[0]), 256'(1));
`else
    check("err_off", 256'(err[0]), '0);
`endif
    tick();
    txn(0, 1, 0, 16'h0020, '0, 0, 0, lat);
    check("rd_0020", rdata[0], '1);

    // Request dropped in BUSY cycle 2 of a write still completes and commits.
    tick();
    txn(0, 0, 1, 16'h0600, {8{32'hFEED_F00D}}, 2, 0, lat);
    check("lat_drop", 256'(lat), 256'(8));
    tick();
    txn(0, 1, 0, 16'h0600, '0, 0, 0, lat);
    check("rd_0600", rdata[0], {8{32'hFEED_F00D}});

    // Random traffic over a small set of lines so reads frequently hit written data.
    for (int n = 0; n < 240; n++) begin
      automatic int i    = int'($urandom_range(0, 1));
      automatic int op   = int'($urandom_range(0, 9));
      automatic bit r    = (op < 5) || (op == 9);
      automatic bit w    = (op >= 5);
      automatic logic [15:0] a = 16'(($urandom_range(0, 15) << 5) | $urandom_range(0, 31));
      automatic int drop = 0;
      automatic int chg  = 0;
      if (i == 0 && $urandom_range(0, 5) == 0) drop = int'($urandom_range(1, 7));
      else if (i == 0 && $urandom_range(0, 5) == 0) chg = int'($urandom_range(1, 7));
      repeat ($urandom_range(1, 3)) tick();
      txn(i, r, w, a, {8{$urandom}}, drop, chg, lat);
      check("rand_lat", 256'(lat), 256'(lat_of(i)));
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
